// File: rtl/ec_range_low_update_if.sv
// Symbol, range/low and enable signals of the first two AV1 range-encoder stages.
// The master drives the symbol and the fed-back range/low; the slave returns the updated range/low.
interface ec_range_low_update_if #(
    parameter int RANGE_WIDTH  = 16,
    parameter int LOW_WIDTH    = 24,
    parameter int SYMBOL_WIDTH = 4
);
    logic                    enable;
    logic [RANGE_WIDTH-1:0]  FL;
    logic [RANGE_WIDTH-1:0]  FH;
    logic [SYMBOL_WIDTH-1:0] SYMBOL;
    logic [SYMBOL_WIDTH:0]   NSYMS;
    logic [RANGE_WIDTH-1:0]  in_range;
    logic [LOW_WIDTH-1:0]    in_low;
    logic [RANGE_WIDTH-1:0]  range;
    logic [LOW_WIDTH-1:0]    low;

    modport master (
        output enable, FL, FH, SYMBOL, NSYMS, in_range, in_low,
        input  range, low
    );

    modport slave (
        input  enable, FL, FH, SYMBOL, NSYMS, in_range, in_low,
        output range, low
    );
endinterface

// File: rtl/ec_range_low_update.sv
// od_ec_encode_q15 front end: stage 1 registers scaled CDF bounds and min-prob offsets,
// stage 2 combines them with the fed-back range/low to give un-normalized range and low.
module ec_range_low_update #(
    parameter int RANGE_WIDTH    = 16,
    parameter int LOW_WIDTH      = 24,
    parameter int SYMBOL_WIDTH   = 4,
    parameter int LUT_ADDR_WIDTH = 8,
    parameter int LUT_DATA_WIDTH = 16
) (
    input  logic                  clk_stage_1,
    input  logic                  reset,
    ec_range_low_update_if.slave  bus
);
    localparam int LUT_DEPTH = 2 ** LUT_ADDR_WIDTH;
    localparam int PROD_W    = 2 * RANGE_WIDTH;
    localparam logic [RANGE_WIDTH-1:0] FL_FIRST = RANGE_WIDTH'(32768);

    // Offset ROMs, addressed {NSYMS-1, SYMBOL}; symbols outside the alphabet read zero.
    logic [LUT_DATA_WIDTH-1:0] lut_u_rom [LUT_DEPTH];
    logic [LUT_DATA_WIDTH-1:0] lut_v_rom [LUT_DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < LUT_DEPTH; gi++) begin : g_lut
            localparam int NS = (gi >> SYMBOL_WIDTH) + 1;
            localparam int S  = gi % (2 ** SYMBOL_WIDTH);
            assign lut_u_rom[gi] = (S < NS) ? LUT_DATA_WIDTH'(4 * (NS - S))     : '0;
            assign lut_v_rom[gi] = (S < NS) ? LUT_DATA_WIDTH'(4 * (NS - 1 - S)) : '0;
        end
    endgenerate

    logic [LUT_ADDR_WIDTH-1:0] lut_addr;
    logic [RANGE_WIDTH-1:0]    uu_next;
    logic [RANGE_WIDTH-1:0]    vv_next;
    logic                      comp_mux_1_next;

    assign lut_addr        = {SYMBOL_WIDTH'(bus.NSYMS - 1'b1), bus.SYMBOL};
    assign uu_next         = bus.FL >> 6;
    assign vv_next         = bus.FH >> 6;
    assign comp_mux_1_next = (bus.FL < FL_FIRST);

    logic [RANGE_WIDTH-1:0]    uu_reg;
    logic [RANGE_WIDTH-1:0]    vv_reg;
    logic [LUT_DATA_WIDTH-1:0] lut_u_reg;
    logic [LUT_DATA_WIDTH-1:0] lut_v_reg;
    logic                      comp_mux_1_reg;

    always_ff @(posedge clk_stage_1) begin
        if (!reset) begin
            uu_reg         <= '0;
            vv_reg         <= '0;
            lut_u_reg      <= '0;
            lut_v_reg      <= '0;
            comp_mux_1_reg <= 1'b0;
        end else if (bus.enable) begin
            uu_reg         <= uu_next;
            vv_reg         <= vv_next;
            lut_u_reg      <= lut_u_rom[lut_addr];
            lut_v_reg      <= lut_v_rom[lut_addr];
            comp_mux_1_reg <= comp_mux_1_next;
        end
    end

    // Stage 2: a cleared register yields v = 0 on the bypass path, i.e. a pass-through.
    logic [RANGE_WIDTH-1:0] r8;
    logic [PROD_W-1:0]      prod_u;
    logic [PROD_W-1:0]      prod_v;
    logic [RANGE_WIDTH-1:0] u;
    logic [RANGE_WIDTH-1:0] v;
    logic [RANGE_WIDTH-1:0] range_next;
    logic [LOW_WIDTH-1:0]   low_next;

    assign r8     = bus.in_range >> 8;
    assign prod_u = PROD_W'(r8) * PROD_W'(uu_reg);
    assign prod_v = PROD_W'(r8) * PROD_W'(vv_reg);
    assign u      = RANGE_WIDTH'((prod_u >> 1) + PROD_W'(lut_u_reg));
    assign v      = RANGE_WIDTH'((prod_v >> 1) + PROD_W'(lut_v_reg));

    always_comb begin
        range_next = bus.in_range - v;
        low_next   = bus.in_low;
        if (comp_mux_1_reg) begin
            range_next = u - v;
            low_next   = bus.in_low + LOW_WIDTH'(bus.in_range) - LOW_WIDTH'(u);
        end
    end

    assign bus.range = range_next;
    assign bus.low   = low_next;
endmodule

// File: tb/tb_ec_range_low_update.sv
// Self-checking bench for ec_range_low_update: directed cases with known answers plus
// randomized pipelined traffic against a symbol-level arithmetic model.
module tb_ec_range_low_update;
    localparam int RW = 16;
    localparam int LW = 24;
    localparam int SW = 4;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    ec_range_low_update_if #(.RANGE_WIDTH(RW), .LOW_WIDTH(LW), .SYMBOL_WIDTH(SW)) bus ();

    ec_range_low_update #(
        .RANGE_WIDTH(RW), .LOW_WIDTH(LW), .SYMBOL_WIDTH(SW),
        .LUT_ADDR_WIDTH(8), .LUT_DATA_WIDTH(16)
    ) dut (
        .clk_stage_1 (clk),
        .reset       (reset),
        .bus         (bus)
    );

    int checks = 0;
    int errors = 0;

    // Symbol-level model: remembers the last accepted symbol, not its derived fields.
    bit m_valid = 1'b0;
    int m_fl, m_fh, m_s, m_ns;

    always @(posedge clk) begin
        if (!reset) begin
            m_valid <= 1'b0;
        end else if (bus.enable) begin
            m_valid <= 1'b1;
            m_fl    <= int'(bus.FL);
            m_fh    <= int'(bus.FH);
            m_s     <= int'(bus.SYMBOL);
            m_ns    <= int'(bus.NSYMS);
        end
    end

    function automatic int wrap(int x, int m);
        return ((x % m) + m) % m;
    endfunction

    function automatic int model_u(int rng);
        int off;
        off = (m_s < m_ns) ? 4 * (m_ns - m_s) : 0;
        return wrap(((rng / 256) * (m_fl / 64)) / 2 + off, 65536);
    endfunction

    function automatic int model_v(int rng);
        int off;
        off = (m_s < m_ns) ? 4 * (m_ns - 1 - m_s) : 0;
        return wrap(((rng / 256) * (m_fh / 64)) / 2 + off, 65536);
    endfunction

    function automatic int model_range(int rng);
        if (!m_valid) return rng;
        if (m_fl < 32768) return wrap(model_u(rng) - model_v(rng), 65536);
        return wrap(rng - model_v(rng), 65536);
    endfunction

    function automatic int model_low(int lo, int rng);
        if (!m_valid || m_fl >= 32768) return lo;
        return wrap(lo + rng - model_u(rng), 1 << 24);
    endfunction

    task automatic drive_sym(int fl, int fh, int s, int ns);
        bus.FL     = RW'(fl);
        bus.FH     = RW'(fh);
        bus.SYMBOL = SW'(s);
        bus.NSYMS  = (SW + 1)'(ns);
    endtask

    task automatic drive_state(int rng, int lo);
        bus.in_range = RW'(rng);
        bus.in_low   = LW'(lo);
    endtask

    task automatic test_reset;
        drive_sym(16384, 0, 1, 2);
        bus.enable = 1'b1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 drive_state(4321, 98765);
        #1;
        checks++;
        if (bus.range !== RW'(4321)) begin
            errors++;
            $display("FAIL reset_range: got %0d expected %0d", bus.range, 4321);
        end
        checks++;
        if (bus.low !== LW'(98765)) begin
            errors++;
            $display("FAIL reset_low: got %0d expected %0d", bus.low, 98765);
        end
        $display("reset: range=%0d low=%0d", bus.range, bus.low);
        reset = 1'b1;
    endtask

    task automatic test_directed;
        int fl[4]  = '{16384, 32768, 20000, 16384};
        int fh[4]  = '{0, 16384, 8000, 0};
        int s[4]   = '{1, 0, 2, 1};
        int ns[4]  = '{2, 2, 4, 2};
        int rng[4] = '{32768, 32768, 40000, 32768};
        int lo[4]  = '{0, 100, 1000, 16776960};
        int er[4]  = '{16388, 16380, 14590, 16388};
        int el[4]  = '{16380, 100, 16656, 16124};
        for (int i = 0; i < 4; i++) begin
            drive_sym(fl[i], fh[i], s[i], ns[i]);
            bus.enable = 1'b1;
            @(posedge clk);
            #1 drive_state(rng[i], lo[i]);
            bus.enable = 1'b0;
            #1;
            checks++;
            if (bus.range !== RW'(er[i])) begin
                errors++;
                $display("FAIL directed%0d_range: got %0d expected %0d", i, bus.range, er[i]);
            end
            checks++;
            if (bus.low !== LW'(el[i])) begin
                errors++;
                $display("FAIL directed%0d_low: got %0d expected %0d", i, bus.low, el[i]);
            end
            $display("directed %0d: range=%0d low=%0d", i, bus.range, bus.low);
        end
    endtask

    task automatic test_hold;
        drive_sym(16384, 0, 1, 2);
        bus.enable = 1'b1;
        @(posedge clk);
        #1 bus.enable = 1'b0;
        drive_sym(20000, 8000, 2, 4);
        @(posedge clk);
        #1 drive_state(32768, 0);
        #1;
        checks++;
        if (bus.range !== RW'(16388)) begin
            errors++;
            $display("FAIL hold_range: got %0d expected %0d", bus.range, 16388);
        end
        checks++;
        if (bus.low !== LW'(16380)) begin
            errors++;
            $display("FAIL hold_low: got %0d expected %0d", bus.low, 16380);
        end
        $display("hold: range=%0d low=%0d", bus.range, bus.low);
    endtask

    task automatic test_mid_reset;
        drive_sym(20000, 8000, 2, 4);
        bus.enable = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        bus.enable = 1'b0;
        drive_state(1234, 5678);
        #1;
        checks++;
        if (bus.range !== RW'(1234)) begin
            errors++;
            $display("FAIL midreset_range: got %0d expected %0d", bus.range, 1234);
        end
        checks++;
        if (bus.low !== LW'(5678)) begin
            errors++;
            $display("FAIL midreset_low: got %0d expected %0d", bus.low, 5678);
        end
        $display("mid reset: range=%0d low=%0d", bus.range, bus.low);
    endtask

    task automatic test_back_to_back;
        int fl[3]  = '{16384, 32768, 20000};
        int fh[3]  = '{0, 16384, 8000};
        int s[3]   = '{1, 0, 2};
        int ns[3]  = '{2, 2, 4};
        int rng[3] = '{32768, 32768, 40000};
        int lo[3]  = '{0, 100, 1000};
        int er[3]  = '{16388, 16380, 14590};
        int el[3]  = '{16380, 100, 16656};
        drive_sym(fl[0], fh[0], s[0], ns[0]);
        bus.enable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 drive_state(rng[i], lo[i]);
            if (i < 2) drive_sym(fl[i+1], fh[i+1], s[i+1], ns[i+1]);
            else bus.enable = 1'b0;
            #1;
            checks++;
            if (bus.range !== RW'(er[i])) begin
                errors++;
                $display("FAIL b2b%0d_range: got %0d expected %0d", i, bus.range, er[i]);
            end
            checks++;
            if (bus.low !== LW'(el[i])) begin
                errors++;
                $display("FAIL b2b%0d_low: got %0d expected %0d", i, bus.low, el[i]);
            end
            $display("back-to-back %0d: range=%0d low=%0d", i, bus.range, bus.low);
        end
    endtask

    task automatic random_sym;
        int fl, fh;
        fl = ($urandom_range(0, 3) == 0) ? 32768 : int'($urandom_range(0, 32767));
        fh = int'($urandom_range(0, (fl > 32767) ? 32767 : fl));
        drive_sym(fl, fh, int'($urandom_range(0, 15)), int'($urandom_range(2, 16)));
        bus.enable = ($urandom_range(0, 4) != 0);
    endtask

    task automatic test_random;
        int rng, lo, er, el;
        random_sym();
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            #1;
            rng = int'($urandom_range(32768, 65535));
            lo  = int'($urandom_range(0, (1 << 24) - 1));
            drive_state(rng, lo);
            random_sym();
            #1;
            er = model_range(rng);
            el = model_low(lo, rng);
            checks++;
            if (bus.range !== RW'(er)) begin
                errors++;
                $display("FAIL random%0d_range: got %0d expected %0d", i, bus.range, er);
            end
            checks++;
            if (bus.low !== LW'(el)) begin
                errors++;
                $display("FAIL random%0d_low: got %0d expected %0d", i, bus.low, el);
            end
            $display("random %0d: in_range=%0d in_low=%0d range=%0d low=%0d", i, rng, lo, bus.range, bus.low);
        end
    endtask

    initial begin
        bus.enable = 1'b0;
        drive_sym(0, 0, 0, 2);
        drive_state(0, 0);
        test_reset();
        test_directed();
        test_hold();
        test_mid_reset();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
